// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: splits 8/16/32-bit core accesses into big-endian bus beats.
// Define CPU_BUS_CTRL_EXT_READY_EN to add bus_rdy for beat stretching.
module cpu_bus_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BUS_WIDTH   = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic                  bus_stb,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_we,
  output logic                  bus_acc_sz,
  output logic [BUS_WIDTH-1:0]  bus_wdata,
`ifdef CPU_BUS_CTRL_EXT_READY_EN
  input  logic                  bus_rdy,
`endif
  input  logic [BUS_WIDTH-1:0]  bus_rdata
);

  localparam bit         WIDE = (BUS_WIDTH == 16);
  localparam logic [3:0] WS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic                  wide_q;
  logic                  err_q;
  logic [2:0]            left_q;
  logic [3:0]            wcnt_q;
  logic [31:0]           wsh_q;
  logic [31:0]           rdata_q;

  logic        accept;
  logic        misal;
  logic        wide_req;
  logic        rdy;
  logic        beat_end;
  logic        last_beat;
  logic [2:0]  n_req;
  logic [31:0] wal;
  logic [15:0] rd_ext;
  logic [15:0] beat_wd;

`ifdef CPU_BUS_CTRL_EXT_READY_EN
  assign rdy = bus_rdy;
`else
  assign rdy = 1'b1;
`endif

  assign accept    = (state == IDLE) && req_valid;
  assign beat_end  = (state == BEAT) && (wcnt_q == WS) && rdy;
  assign last_beat = (left_q == 3'd1);
  assign wide_req  = WIDE && (req_size != 2'd0);
  assign rd_ext    = 16'(bus_rdata);
  assign beat_wd   = wide_q ? wsh_q[31:16] : {8'h00, wsh_q[31:24]};

  // Decode request: alignment check, beat count, MS-first write alignment
  always_comb begin
    misal = 1'b0;
    n_req = 3'd1;
    wal   = req_wdata;
    unique case (req_size)
      2'd0: wal = req_wdata << 24;
      2'd1: begin
        misal = req_addr[0];
        n_req = WIDE ? 3'd1 : 3'd2;
        wal   = req_wdata << 16;
      end
      2'd2: begin
        misal = |req_addr[1:0];
        n_req = WIDE ? 3'd2 : 3'd4;
      end
      default: misal = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = misal ? RESP : BEAT;
      BEAT: if (beat_end && last_beat) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: request latch, wait counting, beat shifting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wide_q  <= 1'b0;
      err_q   <= 1'b0;
      left_q  <= 3'd0;
      wcnt_q  <= 4'd0;
      wsh_q   <= 32'd0;
      rdata_q <= 32'd0;
    end else if (accept) begin
      err_q   <= misal;
      wcnt_q  <= 4'd0;
      rdata_q <= 32'd0;
      if (!misal) begin
        addr_q <= req_addr;
        we_q   <= req_we;
        wide_q <= wide_req;
        left_q <= n_req;
        wsh_q  <= wal;
      end
    end else if (state == BEAT) begin
      if (beat_end) begin
        wcnt_q <= 4'd0;
        left_q <= left_q - 3'd1;
        wsh_q  <= wide_q ? (wsh_q << 16) : (wsh_q << 8);
        if (!we_q) begin
          rdata_q <= wide_q ? {rdata_q[15:0], rd_ext}
                            : {rdata_q[23:0], rd_ext[7:0]};
        end
        if (!last_beat) begin
          addr_q <= addr_q + ADDR_WIDTH'(wide_q ? 2 : 1);
        end
      end else if (wcnt_q != WS) begin
        wcnt_q <= wcnt_q + 4'd1;
      end
    end
  end

  // Output decode from state
  always_comb begin
    req_ready  = (state == IDLE);
    rsp_valid  = (state == RESP);
    rsp_err    = (state == RESP) && err_q;
    rsp_rdata  = 32'd0;
    bus_stb    = (state == BEAT);
    bus_addr   = addr_q;
    bus_we     = 1'b0;
    bus_acc_sz = 1'b0;
    bus_wdata  = '0;
    if (state == RESP && !err_q && !we_q) rsp_rdata = rdata_q;
    if (state == BEAT) begin
      bus_we     = we_q;
      bus_acc_sz = wide_q;
      bus_wdata  = we_q ? BUS_WIDTH'(beat_wd) : '0;
    end
  end

endmodule
